// File: rtl/unsigned_div.sv
// Sequential unsigned divider: a 2*WIDTH dividend divided by a WIDTH divisor.
// Restoring shift-subtract producing one quotient bit per cycle; divide-by-zero and overflow are flagged in one cycle.
module unsigned_div #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2*WIDTH-1:0] in0,
    input  logic [WIDTH-1:0]   in1,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   quot,
    output logic [WIDTH-1:0]   rem,
    output logic               div_zero,
    output logic               ovf
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   rem_acc;
    logic [WIDTH-1:0] q_sh;
    logic [WIDTH-1:0] divisor;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] q_step;
    logic             take_bit;
    logic             zero_case;
    logic             ovf_case;
    logic             last_step;
    logic             accept;

    // One restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
    always_comb begin
        trial    = {rem_acc[WIDTH-1:0], q_sh[WIDTH-1]};
        take_bit = (trial >= {1'b0, divisor});
        rem_step = take_bit ? (trial - {1'b0, divisor}) : trial;
        q_step   = {q_sh[WIDTH-2:0], take_bit};
    end

    // The upper dividend half must be below the divisor or the quotient needs more than WIDTH bits.
    assign zero_case = (state == CALC) && (cnt == '0) && (divisor == '0);
    assign ovf_case  = (state == CALC) && (cnt == '0) && !zero_case && (rem_acc >= {1'b0, divisor});
    assign last_step = (cnt == CW'(WIDTH - 1));
    assign accept    = start && (state != CALC);

    assign busy = (state == CALC);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = CALC;
            CALC: if (zero_case || ovf_case || last_step) state_next = DONE;
            DONE: state_next = start ? CALC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            rem_acc  <= '0;
            q_sh     <= '0;
            divisor  <= '0;
            quot     <= '0;
            rem      <= '0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
        end else if (accept) begin
            cnt     <= '0;
            rem_acc <= {1'b0, in0[2*WIDTH-1:WIDTH]};
            q_sh    <= in0[WIDTH-1:0];
            divisor <= in1;
        end else if (state == CALC) begin
            if (zero_case) begin
                quot     <= '1;
                rem      <= q_sh;
                div_zero <= 1'b1;
                ovf      <= 1'b0;
            end else if (ovf_case) begin
                quot     <= '1;
                rem      <= '0;
                div_zero <= 1'b0;
                ovf      <= 1'b1;
            end else begin
                rem_acc <= rem_step;
                q_sh    <= q_step;
                cnt     <= cnt + CW'(1);
                if (last_step) begin
                    quot     <= q_step;
                    rem      <= rem_step[WIDTH-1:0];
                    div_zero <= 1'b0;
                    ovf      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_unsigned_div.sv
// Directed-vector bench for unsigned_div: table of hand-computed divisions plus
// back-to-back, ignored-start and mid-division reset sequences.
module tb_unsigned_div;
    localparam int W = 16;

    typedef struct {
        logic [2*W-1:0] a;
        logic [W-1:0]   b;
        logic [W-1:0]   q;
        logic [W-1:0]   r;
        logic           dz;
        logic           ov;
        int             lat;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [2*W-1:0] in0 = '0;
    logic [W-1:0]   in1 = '0;
    logic           busy, done, div_zero, ovf;
    logic [W-1:0]   quot, rem;

    int checks = 0;
    int errors = 0;

    unsigned_div #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in0(in0), .in1(in1),
        .busy(busy), .done(done), .quot(quot), .rem(rem),
        .div_zero(div_zero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drives start for one accepting edge; when sync=0 the caller is already at a negedge.
    task automatic launch(input vec_t v, input bit sync);
        if (sync) @(negedge clk);
        in0   = v.a;
        in1   = v.b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Samples on negedges after the accepting edge; n counts edges past it. Optional
    // injection of a competing start at sample n==inject.
    task automatic wait_result(input vec_t v, input int inject);
        int lat = -1;
        int busy_n = 0;
        bit changed = 0;
        logic [W-1:0] q0;
        q0 = quot;
        @(negedge clk);
        for (int n = 0; n < 40; n++) begin
            if (n == inject) begin
                start = 1'b1;
                in0   = 32'h0000_0100;
                in1   = 16'h0003;
            end else if (n == inject + 1) begin
                start = 1'b0;
            end
            if (done) begin
                lat = n;
                break;
            end
            if (busy) busy_n++;
            if (quot !== q0) changed = 1;
            @(negedge clk);
        end
        chk("latency", 64'(lat), 64'(v.lat));
        chk("busy_cycles", 64'(busy_n), 64'(v.lat));
        chk("quot_stable_in_calc", 64'(changed), 64'd0);
        chk("quot", 64'(quot), 64'(v.q));
        chk("rem", 64'(rem), 64'(v.r));
        chk("div_zero", 64'(div_zero), 64'(v.dz));
        chk("ovf", 64'(ovf), 64'(v.ov));
        $display("div %0d / %0d -> quot=%0d rem=%0d dz=%0b ovf=%0b lat=%0d", v.a, v.b, quot, rem, div_zero, ovf, lat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[12];
        vec_t v1, v2;
        int done_cnt;
        tbl[0]  = '{32'd7006652,   16'd5678,   16'd1234,   16'd0,      1'b0, 1'b0, 16};
        tbl[1]  = '{32'd100,       16'd7,      16'd14,     16'd2,      1'b0, 1'b0, 16};
        tbl[2]  = '{32'd1234,      16'd0,      16'hFFFF,   16'd1234,   1'b1, 1'b0, 1};
        tbl[3]  = '{32'h0001_0000, 16'd1,      16'hFFFF,   16'd0,      1'b0, 1'b1, 1};
        tbl[4]  = '{32'hFFFE_0001, 16'hFFFF,   16'hFFFF,   16'd0,      1'b0, 1'b0, 16};
        tbl[5]  = '{32'hFFFE_FFFF, 16'hFFFF,   16'hFFFF,   16'hFFFE,   1'b0, 1'b0, 16};
        tbl[6]  = '{32'd0,         16'd5,      16'd0,      16'd0,      1'b0, 1'b0, 16};
        tbl[7]  = '{32'h1234_5678, 16'h1234,   16'hFFFF,   16'd0,      1'b0, 1'b1, 1};
        tbl[8]  = '{32'd1000000,   16'd1000,   16'd1000,   16'd0,      1'b0, 1'b0, 16};
        tbl[9]  = '{32'd1000001,   16'd3,      16'hFFFF,   16'd0,      1'b0, 1'b1, 1};
        tbl[10] = '{32'hFFFF_FFFF, 16'd0,      16'hFFFF,   16'hFFFF,   1'b1, 1'b0, 1};
        tbl[11] = '{32'd50000,     16'd7,      16'd7142,   16'd6,      1'b0, 1'b0, 16};

        // Reset state
        #12;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_quot", 64'(quot), 64'd0);
        chk("reset_rem", 64'(rem), 64'd0);
        chk("reset_flags", 64'({div_zero, ovf}), 64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        foreach (tbl[i]) begin
            launch(tbl[i], 1'b1);
            wait_result(tbl[i], -1);
            @(negedge clk);
            chk("done_one_cycle", 64'(done), 64'd0);
            chk("idle_after_done", 64'(busy), 64'd0);
            chk("result_held", 64'({quot, rem}), 64'({tbl[i].q, tbl[i].r}));
        end

        // Back-to-back: start held in the done cycle
        v1 = tbl[1];
        v2 = tbl[4];
        launch(v1, 1'b1);
        wait_result(v1, -1);
        launch(v2, 1'b0);
        wait_result(v2, -1);

        // Competing start during cycle 5 is ignored
        launch(tbl[0], 1'b1);
        wait_result(tbl[0], 5);

        // Reset during cycle 8 aborts with no done pulse
        launch(tbl[1], 1'b1);
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_done", 64'(done), 64'd0);
        chk("midreset_quot", 64'(quot), 64'd0);
        chk("midreset_rem", 64'(rem), 64'd0);
        chk("midreset_flags", 64'({div_zero, ovf}), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        done_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        chk("no_done_after_abort", 64'(done_cnt), 64'd0);
        v1 = '{32'd65535, 16'd1, 16'd65535, 16'd0, 1'b0, 1'b0, 16};
        launch(v1, 1'b1);
        wait_result(v1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
